multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3; ALUControl width, legal values 3 or 4; 4 enables sltu, sll, srl and sra.
REQ-002 SHALL have parameter MEM_HANDSHAKE, default 0; 0 means every memory access completes in one cycle, 1 means wait for MemReady.
REQ-003 SHALL have parameter ENABLE_FP, default 1; 1 means flw (0000111) and fsw (0100111) are decoded, 0 means they are illegal.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 op  in  7  opcode, from the instruction register.
REQ-008 funct3  in  3  from the instruction register.
REQ-009 funct7b5  in  1  instruction bit 30.
REQ-010 Zero, Lt, Ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
REQ-011 MemReady  in  1  memory access done; ignored when MEM_HANDSHAKE=0.
REQ-012 PCWrite, IRWrite, MemWrite, RegWrite, FRegWrite  out  1 each  write enables.
REQ-013 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-014 ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-015 ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-016 ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = 4.
REQ-017 ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-018 StoreFp  out  1  store data comes from the FP register file.
REQ-019 ALUControl  out  ALUCTRL_W  ALU operation: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9.
REQ-020 Illegal  out  1  sticky illegal-instruction flag.

Function
REQ-021 States SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP. All outputs are Moore, except the branch PCWrite and the waits gated by MemReady.
REQ-022 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite pulse only in the cycle the access completes; that cycle moves to DECODE, otherwise FETCH holds.
REQ-023 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add, so branch and jump targets are precomputed. DECODE then steps by op: lw/flw->MEMADR, sw/fsw->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, jal->JAL, any other->TRAP.
REQ-024 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add. ImmSrc is 00 for loads and 01 for stores. Loads go to MEMREAD, stores go to MEMWRITE.
REQ-025 MEMREAD SHALL drive AdrSrc=1 and hold until the access completes, then go to MEMWB. MEMWB SHALL drive ResultSrc=01, assert RegWrite (lw) or FRegWrite (flw), then go to FETCH.
REQ-026 MEMWRITE SHALL drive AdrSrc=1 and MemWrite=1 until the access completes, with StoreFp=1 for fsw, then go to FETCH. MemWrite SHALL be exactly one cycle when MEM_HANDSHAKE=0.
REQ-027 EXECR and EXECI SHALL drive ALUSrcA=10, with ALUSrcB=00 (EXECR) or 01 (EXECI) and ImmSrc=00, then go to ALUWB. ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-028 ALU decode:
- funct3 000: sub only when op[5]=1 and funct7b5=1, otherwise add.
- 111 and, 110 or, 100 xor, 010 slt.
- When ALUCTRL_W=4: 011 sltu, 001 sll, 101 srl/sra by funct7b5.
- A funct3 unsupported at the configured width SHALL go to TRAP from DECODE.
REQ-029 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = taken, where taken is by funct3:
- 000 Zero; 001 !Zero; 100 Lt; 101 !Lt; 110 Ltu; 111 !Ltu.
- 010 and 011 SHALL go to TRAP from DECODE.
- BRANCH then goes to FETCH.
REQ-030 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-031 TRAP SHALL set Illegal=1, hold all enables at 0, and stay in TRAP until reset.
REQ-032 Outside the states named above, every write enable SHALL be 0 and every select SHALL be 0.
REQ-033 An unreachable state encoding SHALL go to FETCH on the next clock.

Reset
REQ-034 While reset_n=0 at a rising edge, the state SHALL be FETCH and Illegal SHALL be 0. Reset applies in any state, including a MemReady wait or TRAP.
REQ-035 The first cycle after reset SHALL be a FETCH; no write enable is asserted while reset_n=0.

Structure
REQ-036 Package riscv_ctrl_pkg SHALL hold: the state enum, the opcode constants, the ALUControl codes, and the src-select encodings.
REQ-037 ALU decode SHALL be sub-module aludec_param, parameterised by ALUCTRL_W. The FSM stays in multicycle_controller.

Verification
REQ-038 lw, MEM_HANDSHAKE=0 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB: five cycles, with RegWrite=1 only in cycle 5.
REQ-039 sw, MEM_HANDSHAKE=1, MemReady low for 3 cycles -> MemWrite held high for 4 cycles, then FETCH.
REQ-040 Branches, with 001 (bne) Zero=1, 101 (bge) Lt=0, 110 (bltu) Ltu=0 -> PCWrite in BRANCH = 0, 1, 0 respectively.
REQ-041 R-type funct3=101, funct7b5=1 -> ALUControl=9 when ALUCTRL_W=4; Illegal=1 and TRAP when ALUCTRL_W=3.
REQ-042 op=1110011, then reset_n low for 1 cycle -> Illegal=1 and TRAP held; after reset, Illegal=0 and FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StTrap
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpFload  = 7'b0000111;
    localparam logic [6:0] OpFstore = 7'b0100111;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/aludec_param.sv
// ALU operation decode for R-type and I-type ALU instructions.
module aludec_param
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  logic                 op5,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 legal
);

    // sltu and the shifts only have codes when the control bus is 4 bits wide
    localparam bit Wide = (ALUCTRL_W >= 4);

    always_comb begin
        alu_control = AluAdd[ALUCTRL_W-1:0];
        legal       = 1'b1;
        case (funct3)
            3'b000: alu_control = (op5 && funct7b5) ? AluSub[ALUCTRL_W-1:0]
                                                    : AluAdd[ALUCTRL_W-1:0];
            3'b111: alu_control = AluAnd[ALUCTRL_W-1:0];
            3'b110: alu_control = AluOr[ALUCTRL_W-1:0];
            3'b100: alu_control = AluXor[ALUCTRL_W-1:0];
            3'b010: alu_control = AluSlt[ALUCTRL_W-1:0];
            3'b011: begin
                alu_control = AluSltu[ALUCTRL_W-1:0];
                legal       = Wide;
            end
            3'b001: begin
                alu_control = AluSll[ALUCTRL_W-1:0];
                legal       = Wide;
            end
            3'b101: begin
                alu_control = funct7b5 ? AluSra[ALUCTRL_W-1:0] : AluSrl[ALUCTRL_W-1:0];
                legal       = Wide;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore outputs per state, optional memory handshake.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W     = 3,
    parameter int unsigned MEM_HANDSHAKE = 0,
    parameter int unsigned ENABLE_FP     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 FRegWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic                 StoreFp,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal
);

    localparam bit FpEn  = (ENABLE_FP != 0);
    localparam bit MemHs = (MEM_HANDSHAKE != 0);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [ALUCTRL_W-1:0] alu_dec;
    logic                 alu_legal;
    logic                 mem_done;
    logic                 is_fp_load, is_fp_store, is_load, is_store;
    logic                 br_legal, br_cond, br_taken;

    aludec_param #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_aludec (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_control(alu_dec),
        .legal      (alu_legal)
    );

    assign mem_done    = !MemHs || MemReady;
    assign is_fp_load  = FpEn && (op == OpFload);
    assign is_fp_store = FpEn && (op == OpFstore);
    assign is_load     = (op == OpLoad) || is_fp_load;
    assign is_store    = (op == OpStore) || is_fp_store;

    // funct3[0] inverts the base condition (bne/bge/bgeu)
    always_comb begin
        br_legal = (funct3[2:1] != 2'b01);
        case (funct3[2:1])
            2'b00:   br_cond = Zero;
            2'b10:   br_cond = Lt;
            2'b11:   br_cond = Ltu;
            default: br_cond = 1'b0;
        endcase
        br_taken = br_cond ^ funct3[0];
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        FRegWrite  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = ResAluOut;
        ALUSrcA    = SrcAPc;
        ALUSrcB    = SrcBRs2;
        ImmSrc     = ImmI;
        StoreFp    = 1'b0;
        ALUControl = AluAdd[ALUCTRL_W-1:0];

        case (state_q)
            StFetch: begin
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                if (mem_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                ImmSrc  = ImmB;
                if (is_load || is_store) begin
                    state_d = StMemAdr;
                end else if (op == OpRtype) begin
                    state_d = alu_legal ? StExecR : StTrap;
                end else if (op == OpItype) begin
                    state_d = alu_legal ? StExecI : StTrap;
                end else if (op == OpBranch) begin
                    state_d = br_legal ? StBranch : StTrap;
                end else if (op == OpJal) begin
                    state_d = StJal;
                end else begin
                    state_d = StTrap;
                end
            end
            StMemAdr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                ImmSrc  = is_store ? ImmS : ImmI;
                state_d = is_store ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (mem_done) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = !is_fp_load;
                FRegWrite = is_fp_load;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                StoreFp  = is_fp_store;
                if (mem_done) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA    = SrcARs1;
                ALUSrcB    = SrcBRs2;
                ALUControl = alu_dec;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcA    = SrcARs1;
                ALUSrcB    = SrcBImm;
                ALUControl = alu_dec;
                state_d    = StAluWb;
            end
            StAluWb: begin
                ResultSrc = ResAluOut;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcA    = SrcARs1;
                ALUSrcB    = SrcBRs2;
                ALUControl = AluSub[ALUCTRL_W-1:0];
                PCWrite    = br_taken;
                state_d    = StFetch;
            end
            StJal: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBFour;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase

        // Reset overrides the Moore decode so no write can slip out while held
        if (!reset_n) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            FRegWrite = 1'b0;
        end
    end

    assign illegal_d = illegal_q || (state_d == StTrap);
    assign Illegal   = illegal_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Two controller configurations checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw, irw, memw, regw, fregw, adr;
        logic [1:0] res, srca, srcb, imm;
        logic       sfp;
        logic [3:0] alu;
        logic       ill;
    } outs_t;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] FLW  = 7'b0000111;
    localparam logic [6:0] FSW  = 7'b0100111;
    localparam logic [6:0] SYS  = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n, f7, zero, lt, ltu, mr;
    logic [1:0][6:0] op;
    logic [1:0][2:0] f3;
    logic [1:0]      pcw, irw, memw, regw, fregw, adr, sfp, ill;
    logic [1:0][1:0] res, srca, srcb, imm;
    logic [3:0]      alu0;
    logic [2:0]      alu1;
    outs_t           act [2];

    int total = 0;
    int bad   = 0;

    // inst 0: 4-bit ALU, handshake, FP on; inst 1: 3-bit ALU, single-cycle memory, FP off
    multicycle_controller #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1), .ENABLE_FP(1)) u_dut0 (
        .clk(clk), .reset_n(rst_n[0]), .op(op[0]), .funct3(f3[0]), .funct7b5(f7[0]),
        .Zero(zero[0]), .Lt(lt[0]), .Ltu(ltu[0]), .MemReady(mr[0]),
        .PCWrite(pcw[0]), .IRWrite(irw[0]), .MemWrite(memw[0]), .RegWrite(regw[0]),
        .FRegWrite(fregw[0]), .AdrSrc(adr[0]), .ResultSrc(res[0]), .ALUSrcA(srca[0]),
        .ALUSrcB(srcb[0]), .ImmSrc(imm[0]), .StoreFp(sfp[0]), .ALUControl(alu0),
        .Illegal(ill[0])
    );

    multicycle_controller #(.ALUCTRL_W(3), .MEM_HANDSHAKE(0), .ENABLE_FP(0)) u_dut1 (
        .clk(clk), .reset_n(rst_n[1]), .op(op[1]), .funct3(f3[1]), .funct7b5(f7[1]),
        .Zero(zero[1]), .Lt(lt[1]), .Ltu(ltu[1]), .MemReady(mr[1]),
        .PCWrite(pcw[1]), .IRWrite(irw[1]), .MemWrite(memw[1]), .RegWrite(regw[1]),
        .FRegWrite(fregw[1]), .AdrSrc(adr[1]), .ResultSrc(res[1]), .ALUSrcA(srca[1]),
        .ALUSrcB(srcb[1]), .ImmSrc(imm[1]), .StoreFp(sfp[1]), .ALUControl(alu1),
        .Illegal(ill[1])
    );

    assign act[0] = {pcw[0], irw[0], memw[0], regw[0], fregw[0], adr[0], res[0], srca[0],
                     srcb[0], imm[0], sfp[0], alu0, ill[0]};
    assign act[1] = {pcw[1], irw[1], memw[1], regw[1], fregw[1], adr[1], res[1], srca[1],
                     srcb[1], imm[1], sfp[1], {1'b0, alu1}, ill[1]};

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void alu_ref(input logic op5, input logic [2:0] f, input logic f7b,
                                    input bit wide, output logic [3:0] code, output bit ok);
        ok = 1'b1;
        case (f)
            3'd0: code = (op5 && f7b) ? 4'd1 : 4'd0;
            3'd7: code = 4'd2;
            3'd6: code = 4'd3;
            3'd4: code = 4'd4;
            3'd2: code = 4'd5;
            3'd3: begin code = 4'd6; ok = wide; end
            3'd1: begin code = 4'd7; ok = wide; end
            default: begin code = f7b ? 4'd9 : 4'd8; ok = wide; end
        endcase
    endfunction

    // Called just after a falling edge; checks outputs, then waits for the next falling edge
    task automatic step(input int k, input outs_t e, input logic m, input string tag);
        mr[k] = m;
        #1;
        total++;
        assert (act[k] === e) else begin
            bad++;
            $error("FAIL %s inst%0d: got %h want %h", tag, k, act[k], e);
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input int k, input logic [6:0] iop, input logic [2:0] if3,
                             input logic if7, input logic z, input logic l, input logic lu,
                             input int wf_in, input int wm_in, output bit trapped);
        outs_t      o;
        int         wf, wm;
        logic [3:0] code;
        bit         ok, hs, fp, is_ld, is_st, taken;
        hs = (k == 0);
        fp = (k == 0);
        wf = hs ? wf_in : 0;
        wm = hs ? wm_in : 0;
        op[k] = iop; f3[k] = if3; f7[k] = if7;
        zero[k] = z; lt[k] = l; ltu[k] = lu;
        trapped = 1'b0;

        for (int i = 0; i <= wf; i++) begin
            o = '0; o.srcb = 2'b10; o.res = 2'b10;
            if (i == wf) begin o.irw = 1'b1; o.pcw = 1'b1; end
            step(k, o, hs ? logic'(i == wf) : rnd1(), "fetch");
        end
        o = '0; o.srca = 2'b01; o.srcb = 2'b01; o.imm = 2'b10;
        step(k, o, rnd1(), "decode");

        is_ld = (iop == LW) || (fp && iop == FLW);
        is_st = (iop == SW) || (fp && iop == FSW);
        alu_ref(iop[5], if3, if7, (k == 0), code, ok);

        if (is_ld || is_st) begin
            o = '0; o.srca = 2'b10; o.srcb = 2'b01; o.imm = is_st ? 2'b01 : 2'b00;
            step(k, o, rnd1(), "memadr");
            for (int i = 0; i <= wm; i++) begin
                o = '0; o.adr = 1'b1;
                if (is_st) begin o.memw = 1'b1; o.sfp = (iop == FSW); end
                step(k, o, hs ? logic'(i == wm) : rnd1(), is_st ? "memwrite" : "memread");
            end
            if (is_ld) begin
                o = '0; o.res = 2'b01; o.regw = (iop == LW); o.fregw = (iop == FLW);
                step(k, o, rnd1(), "memwb");
            end
        end else if ((iop == RT || iop == IT) && ok) begin
            o = '0; o.srca = 2'b10; o.srcb = (iop == RT) ? 2'b00 : 2'b01; o.alu = code;
            step(k, o, rnd1(), "exec");
            o = '0; o.regw = 1'b1;
            step(k, o, rnd1(), "aluwb");
        end else if (iop == BR && if3[2:1] != 2'b01) begin
            case (if3)
                3'd0:    taken = z;
                3'd1:    taken = !z;
                3'd4:    taken = l;
                3'd5:    taken = !l;
                3'd6:    taken = lu;
                default: taken = !lu;
            endcase
            o = '0; o.srca = 2'b10; o.alu = 4'd1; o.pcw = taken;
            step(k, o, rnd1(), "branch");
        end else if (iop == JAL) begin
            o = '0; o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1;
            step(k, o, rnd1(), "jal");
            o = '0; o.regw = 1'b1;
            step(k, o, rnd1(), "jal_wb");
        end else begin
            for (int i = 0; i < 3; i++) begin
                o = '0; o.ill = 1'b1;
                step(k, o, rnd1(), "trap");
            end
            trapped = 1'b1;
        end
    endtask

    // One reset cycle out of TRAP: flag still visible before the edge, FETCH afterwards
    task automatic trap_reset(input int k);
        outs_t o;
        o = '0; o.ill = 1'b1;
        rst_n[k] = 1'b0;
        step(k, o, 1'b1, "trap_in_reset");
        rst_n[k] = 1'b1;
    endtask

    task automatic rand_run(input int k, input int n);
        logic [6:0] ops [8];
        logic [6:0] iop;
        int         sel;
        bit         t;
        ops = '{LW, SW, RT, IT, BR, JAL, FLW, FSW};
        for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       iop = ops[sel];
            else if (sel == 8) iop = SYS;
            else               iop = 7'($urandom);
            run_instr(k, iop, 3'($urandom), rnd1(), rnd1(), rnd1(), rnd1(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), t);
            if (t) trap_reset(k);
        end
    endtask

    initial begin
        outs_t o;
        bit    t;
        rst_n = 2'b00; op = '0; f3 = '0; f7 = '0;
        zero = '0; lt = '0; ltu = '0; mr = '0;
        @(negedge clk);
        o = '0; o.srcb = 2'b10; o.res = 2'b10;
        step(0, o, 1'b1, "reset_state");
        step(1, o, 1'b1, "reset_state");

        rst_n = 2'b01;
        run_instr(0, LW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2, t);
        run_instr(0, SW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, t);
        run_instr(0, RT,  3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(0, BR,  3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, t);
        run_instr(0, BR,  3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(0, BR,  3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(0, FLW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, t);
        run_instr(0, FSW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, t);
        run_instr(0, IT,  3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(0, JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(0, SYS, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        trap_reset(0);
        rand_run(0, 60);

        rst_n = 2'b10;
        run_instr(1, LW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(1, RT,  3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, t);
        trap_reset(1);
        run_instr(1, FLW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        trap_reset(1);
        run_instr(1, SW,  3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(1, RT,  3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, t);
        run_instr(1, BR,  3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, t);
        trap_reset(1);
        rand_run(1, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
